// File: rtl/mips_cpu_load_store_unit.sv
// Avalon-MM load/store master for the multicycle MIPS core: one request at a time,
// LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW. Optional perf counters behind MIPS_LSU_PERF_EN.
module mips_cpu_load_store_unit #(
    parameter int STALL_CNT_W     = 32,
    parameter bit WORD_ALIGN_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        memread,
    output logic        memwrite,
    input  logic        waitrequest,
    output logic [31:0] memwritedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] memreaddata
`ifdef MIPS_LSU_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] perf_ops,
    output logic [STALL_CNT_W-1:0] perf_stalls
`endif
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] rt_old_q;
    logic [31:0] mem_address_q, memwritedata_q, resp_rdata_q;
    logic        memread_q, memwrite_q, resp_error_q;
    logic [3:0]  byteenable_q;

    logic [1:0]  req_off;
    logic        req_legal, req_misalign, req_store, req_err;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic        accept, bus_done;

    assign req_off  = req_addr[1:0];
    assign accept   = (state_q == S_IDLE) && req_valid;
    assign bus_done = (state_q == S_BUS) && !waitrequest;

    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        req_legal    = 1'b1;
        req_misalign = 1'b0;
        req_store    = 1'b0;
        req_be       = 4'b0000;
        req_wd       = 32'd0;
        case (req_op)
            OP_LB, OP_LBU: req_be = 4'b0001 << req_off;
            OP_LH, OP_LHU: begin
                req_misalign = req_off[0];
                req_be       = req_off[1] ? 4'b1100 : 4'b0011;
            end
            OP_LW: begin
                req_misalign = |req_off;
                req_be       = 4'b1111;
            end
            OP_LWL: req_be = 4'((4'b0010 << req_off) - 4'd1);
            OP_LWR: req_be = 4'b1111 << req_off;
            OP_SB: begin
                req_store = 1'b1;
                req_be    = 4'b0001 << req_off;
                req_wd    = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
                req_store    = 1'b1;
                req_misalign = req_off[0];
                req_be       = req_off[1] ? 4'b1100 : 4'b0011;
                req_wd       = {2{req_wdata[15:0]}};
            end
            OP_SW: begin
                req_store    = 1'b1;
                req_misalign = |req_off;
                req_be       = 4'b1111;
                req_wd       = req_wdata;
            end
            default: req_legal = 1'b0;
        endcase
        req_err = !req_legal || req_misalign;
    end

    // Load result formed from the live read data on the completing edge.
    logic [31:0] rd_byte_sh, load_result;
    logic [15:0] rd_half;
    logic [4:0]  sh_l, sh_r;

    always_comb begin
        rd_byte_sh  = memreaddata >> {off_q, 3'b000};
        rd_half     = off_q[1] ? memreaddata[31:16] : memreaddata[15:0];
        sh_l        = {2'd3 - off_q, 3'b000};
        sh_r        = {off_q, 3'b000};
        load_result = 32'd0;
        case (op_q)
            OP_LB:  load_result = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
            OP_LBU: load_result = {24'd0, rd_byte_sh[7:0]};
            OP_LH:  load_result = {{16{rd_half[15]}}, rd_half};
            OP_LHU: load_result = {16'd0, rd_half};
            OP_LW:  load_result = memreaddata;
            OP_LWL: load_result = (memreaddata << sh_l) | (rt_old_q & ~(32'hFFFF_FFFF << sh_l));
            OP_LWR: load_result = (memreaddata >> sh_r) | (rt_old_q & ~(32'hFFFF_FFFF >> sh_r));
            default: load_result = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_err ? S_RESP : S_BUS;
            S_BUS:   if (!waitrequest) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= 4'd0;
            off_q          <= 2'd0;
            rt_old_q       <= 32'd0;
            mem_address_q  <= 32'd0;
            memwritedata_q <= 32'd0;
            byteenable_q   <= 4'd0;
            memread_q      <= 1'b0;
            memwrite_q     <= 1'b0;
            resp_rdata_q   <= 32'd0;
            resp_error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= req_op;
                off_q        <= req_off;
                rt_old_q     <= req_rt_old;
                resp_rdata_q <= 32'd0;
                resp_error_q <= req_err;
                if (!req_err) begin
                    mem_address_q  <= WORD_ALIGN_ADDR ? {req_addr[31:2], 2'b00} : req_addr;
                    memwritedata_q <= req_wd;
                    byteenable_q   <= req_be;
                    memread_q      <= !req_store;
                    memwrite_q     <= req_store;
                end
            end
            if (bus_done) begin
                memread_q  <= 1'b0;
                memwrite_q <= 1'b0;
                if (memread_q) resp_rdata_q <= load_result;
            end
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_RESP);
    assign resp_rdata   = resp_rdata_q;
    assign resp_error   = resp_error_q;
    assign mem_address  = mem_address_q;
    assign memread      = memread_q;
    assign memwrite     = memwrite_q;
    assign memwritedata = memwritedata_q;
    assign byteenable   = byteenable_q;

`ifdef MIPS_LSU_PERF_EN
    logic [STALL_CNT_W-1:0] perf_ops_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops_q    <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (bus_done) perf_ops_q <= perf_ops_q + 1'b1;
            if ((state_q == S_BUS) && waitrequest) perf_stalls_q <= perf_stalls_q + 1'b1;
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_stalls = perf_stalls_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^STALL_CNT_W;
`endif

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// Directed self-checking bench for mips_cpu_load_store_unit (default WORD_ALIGN_ADDR=1);
// also checks the perf counters when MIPS_LSU_PERF_EN is defined.
module tb_mips_cpu_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_rt_old;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        memread, memwrite, waitrequest;
    logic [31:0] memwritedata;
    logic [3:0]  byteenable;
    logic [31:0] memreaddata;
`ifdef MIPS_LSU_PERF_EN
    logic [31:0] perf_ops, perf_stalls;
`endif

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;
    int exp_stalls = 0;

    always #5 clk = ~clk;

    mips_cpu_load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rt_old   (req_rt_old),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .memread      (memread),
        .memwrite     (memwrite),
        .waitrequest  (waitrequest),
        .memwritedata (memwritedata),
        .byteenable   (byteenable),
        .memreaddata  (memreaddata)
`ifdef MIPS_LSU_PERF_EN
        ,
        .perf_ops     (perf_ops),
        .perf_stalls  (perf_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; BUS lasts waits+1 cycles. While busy a bogus request is held on the
    // inputs and must be ignored.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rt_old,
                         input logic [31:0] rdata, input int waits, input logic exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
        logic is_store;
        is_store = op[3];
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        check({tag, ".idle_resp"}, 32'(resp_valid), 32'd0);
        req_valid   = 1'b1;
        req_op      = op;
        req_addr    = addr;
        req_wdata   = wdata;
        req_rt_old  = rt_old;
        memreaddata = rdata;
        waitrequest = (waits > 0);
        @(posedge clk);
        #1;
        req_op     = 4'd0;
        req_addr   = 32'h0000_0FFC;
        req_wdata  = 32'h5555_5555;
        req_rt_old = 32'h6666_6666;
        if (!exp_err) begin
            for (int i = 0; i <= waits; i++) begin
                @(negedge clk);
                check({tag, ".rd"}, 32'(memread), 32'(!is_store));
                check({tag, ".wr"}, 32'(memwrite), 32'(is_store));
                check({tag, ".addr"}, mem_address, {addr[31:2], 2'b00});
                check({tag, ".be"}, 32'(byteenable), 32'(exp_be));
                if (is_store) check({tag, ".wdata"}, memwritedata, exp_wdata);
                check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
                check({tag, ".busy_resp"}, 32'(resp_valid), 32'd0);
                if (i == waits) waitrequest = 1'b0;
            end
            exp_ops++;
            exp_stalls += waits;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_error"}, 32'(resp_error), 32'(exp_err));
        check({tag, ".resp_rdata"}, resp_rdata, exp_err ? 32'd0 : exp_rdata);
        check({tag, ".resp_rd"}, 32'(memread), 32'd0);
        check({tag, ".resp_wr"}, 32'(memwrite), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_op      = 4'd0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        req_rt_old  = 32'd0;
        waitrequest = 1'b0;
        memreaddata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_error", 32'(resp_error), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.rd", 32'(memread), 32'd0);
        check("rst.wr", 32'(memwrite), 32'd0);
        check("rst.addr", mem_address, 32'd0);
        check("rst.wdata", memwritedata, 32'd0);
        check("rst.be", 32'(byteenable), 32'd0);
        reset = 1'b0;

        //     tag      op     addr          wdata         rt_old        rdata         w  err   be       wdata_exp     rdata_exp
        do_op("lb103",  4'd0,  32'h103,      32'h0,        32'h0,        32'h80FF_FFFF, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80);
        do_op("sh202",  4'd9,  32'h202,      32'h1234_ABCD, 32'h0,       32'h0,        3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_op("lw101",  4'd4,  32'h101,      32'h0,        32'h0,        32'hFFFF_FFFF, 0, 1'b1, 4'b0000, 32'h0,        32'h0);
        do_op("lwl1",   4'd5,  32'h1,        32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0, 4'b0011, 32'h0,       32'hCCDD_3344);
        do_op("lwr1",   4'd6,  32'h1,        32'h0,        32'h1122_3344, 32'hAABB_CCDD, 1, 1'b0, 4'b1110, 32'h0,       32'h11AA_BBCC);
        do_op("lwl0",   4'd5,  32'h40,       32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0, 4'b0001, 32'h0,       32'hDD22_3344);
        do_op("lwl3",   4'd5,  32'h43,       32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0, 4'b1111, 32'h0,       32'hAABB_CCDD);
        do_op("lwr0",   4'd6,  32'h40,       32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0, 4'b1111, 32'h0,       32'hAABB_CCDD);
        do_op("lwr3",   4'd6,  32'h43,       32'h0,        32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0, 4'b1000, 32'h0,       32'h1122_33AA);
        do_op("lbu102", 4'd1,  32'h102,      32'h0,        32'h0,        32'h12B4_5678, 0, 1'b0, 4'b0100, 32'h0,        32'h0000_00B4);
        do_op("lh202",  4'd2,  32'h202,      32'h0,        32'h0,        32'h8001_7FFF, 2, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
        do_op("lhu200", 4'd3,  32'h200,      32'h0,        32'h0,        32'h8001_F00D, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D);
        do_op("lw300",  4'd4,  32'h300,      32'h0,        32'h0,        32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D);
        do_op("sb301",  4'd8,  32'h301,      32'hDEAD_BEEF, 32'h0,       32'h0,        0, 1'b0, 4'b0010, 32'hEFEF_EFEF, 32'h0);
        do_op("sw304",  4'd10, 32'h304,      32'hDEAD_BEEF, 32'h0,       32'h0,        1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        do_op("sh201",  4'd9,  32'h201,      32'h1234_5678, 32'h0,       32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
        do_op("sw302",  4'd10, 32'h302,      32'h1234_5678, 32'h0,       32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
        do_op("lhu3",   4'd3,  32'h3,        32'h0,        32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
        do_op("op7",    4'd7,  32'h100,      32'h0,        32'h0,        32'hFFFF_FFFF, 0, 1'b1, 4'b0000, 32'h0,        32'h0);
        do_op("op15",   4'd15, 32'h100,      32'h0,        32'h0,        32'hFFFF_FFFF, 0, 1'b1, 4'b0000, 32'h0,        32'h0);

`ifdef MIPS_LSU_PERF_EN
        @(negedge clk);
        check("perf.ops", perf_ops, 32'(exp_ops));
        check("perf.stalls", perf_stalls, 32'(exp_stalls));
`endif

        // Reset in the middle of a stalled read: the bus drops and no response follows.
        @(negedge clk);
        req_valid   = 1'b1;
        req_op      = 4'd4;
        req_addr    = 32'h400;
        waitrequest = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid.rd_before", 32'(memread), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid.rd_after", 32'(memread), 32'd0);
        check("mid.ready", 32'(req_ready), 32'd1);
        check("mid.resp_valid", 32'(resp_valid), 32'd0);
        reset       = 1'b0;
        waitrequest = 1'b0;
        exp_ops     = 0;
        exp_stalls  = 0;
        @(negedge clk);
        check("mid.resp_later", 32'(resp_valid), 32'd0);
        check("mid.rd_later", 32'(memread), 32'd0);

        do_op("post_lb", 4'd0, 32'h500, 32'h0, 32'h0, 32'h0000_7F00, 0, 1'b0, 4'b0001, 32'h0, 32'h0);
`ifdef MIPS_LSU_PERF_EN
        @(negedge clk);
        check("perf.ops_post", perf_ops, 32'(exp_ops));
        check("perf.stalls_post", perf_stalls, 32'(exp_stalls));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // memread and memwrite must never be asserted together.
    always @(negedge clk) begin
        if (!reset) check("excl_rd_wr", 32'(memread & memwrite), 32'd0);
    end

endmodule
